uart_tx_arbiter: RTL

Round-robin scheduler that shares one `uart_tx` serializer between `NUM_REQ` byte producers. It picks one pending requester and latches that requester's byte and parity settings. It then issues a single-cycle `DATA_VALID` to the serializer and tracks its `Busy` through the whole frame before granting again. It sits between the producer logic and the serializer's `P_DATA`/`DATA_VALID`/`PAR_EN`/`PAR_TYP`/`Busy` pins.

---
 rtl/uart_tx_arb_pkg.sv | 19 +
 rtl/uart_tx_rr_picker.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared states, defaults and pointer helper for the uart_tx arbiter
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    SEND  = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam int NUM_REQ_DEF     = 4;
  localparam int ACK_TIMEOUT_DEF = 4;

  // Next round-robin start index after idx, wrapping at n.
  function automatic int rr_advance(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_rr_picker.sv
// rtl/uart_tx_rr_picker.sv - combinational round-robin winner search starting at a pointer
module uart_tx_rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_ptr,
  output logic               o_any,
  output logic [IW-1:0]      o_winner
);

  int w_idx;

  // Walk offsets from farthest to nearest so the first valid index at or after i_ptr wins last.
  always_comb begin
    o_any    = |i_valid;
    o_winner = '0;
    w_idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = (int'(i_ptr) + i) % NUM_REQ;
      if (i_valid[w_idx]) begin
        o_winner = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx; UART_TX_ARB_PARCFG_EN selects per-requester parity
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
`ifdef UART_TX_ARB_PARCFG_EN
  input  logic [NUM_REQ-1:0]         req_par_en,
  input  logic [NUM_REQ-1:0]         req_par_typ,
`else
  input  logic                       cfg_par_en,
  input  logic                       cfg_par_typ,
`endif
  output logic [7:0]                 tx_p_data,
  output logic                       tx_data_valid,
  output logic                       tx_par_en,
  output logic                       tx_par_typ,
  input  logic                       tx_busy,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  arb_state_e         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [CW-1:0]      r_ack_cnt;
  logic [7:0]         r_p_data;
  logic               r_data_valid;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_grant_valid;
  logic [IW-1:0]      r_grant_id;
  logic               r_err;
  logic               r_par_en;
  logic               r_par_typ;

  logic               w_any;
  logic [IW-1:0]      w_winner;
  logic [7:0]         w_win_data;
  logic               w_win_par_en;
  logic               w_win_par_typ;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [CW-1:0]      w_ack_next;

  uart_tx_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_valid  (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Mux the winner's byte, parity bits and ready one-hot out of the packed request buses.
  always_comb begin
    w_win_data    = '0;
    w_win_par_en  = 1'b0;
    w_win_par_typ = 1'b0;
    w_win_onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IW'(i)) begin
        w_win_data      = req_data[i*8 +: 8];
        w_win_onehot[i] = 1'b1;
`ifdef UART_TX_ARB_PARCFG_EN
        w_win_par_en    = req_par_en[i];
        w_win_par_typ   = req_par_typ[i];
`endif
      end
    end
`ifndef UART_TX_ARB_PARCFG_EN
    w_win_par_en  = cfg_par_en;
    w_win_par_typ = cfg_par_typ;
`endif
  end

  assign w_ack_next = r_ack_cnt + CW'(1);

  // Frame ownership FSM; byte and parity registers only load at a grant so they hold through the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ARB;
      r_rr_ptr      <= '0;
      r_ack_cnt     <= '0;
      r_p_data      <= '0;
      r_data_valid  <= 1'b0;
      r_req_ready   <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_err         <= 1'b0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_req_ready  <= '0;
      r_err        <= 1'b0;
      case (r_state)
        ARB: begin
          // A busy serializer here means a frame survived a reset; let it finish first.
          if (w_any && !tx_busy) begin
            r_p_data      <= w_win_data;
            r_par_en      <= w_win_par_en;
            r_par_typ     <= w_win_par_typ;
            r_data_valid  <= 1'b1;
            r_req_ready   <= w_win_onehot;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_winner;
            r_rr_ptr      <= IW'(rr_advance(int'(w_winner), NUM_REQ));
            r_state       <= SEND;
          end
        end
        SEND: begin
          r_ack_cnt <= '0;
          r_state   <= ACK;
        end
        ACK: begin
          if (tx_busy) begin
            r_state <= DRAIN;
          end else begin
            r_ack_cnt <= w_ack_next;
            // Serializer never took the byte: drop it and report, no retry.
            if (w_ack_next == CW'(ACK_TIMEOUT)) begin
              r_err         <= 1'b1;
              r_grant_valid <= 1'b0;
              r_state       <= ARB;
            end
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            r_grant_valid <= 1'b0;
            r_state       <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign tx_p_data     = r_p_data;
  assign tx_data_valid = r_data_valid;
  assign tx_par_en     = r_par_en;
  assign tx_par_typ    = r_par_typ;
  assign req_ready     = r_req_ready;
  assign grant_valid   = r_grant_valid;
  assign grant_id      = r_grant_id;
  assign tx_err        = r_err;

endmodule
